// File: rtl/sar_search_ctrl_if.sv
// Comparator-side bundle for the SAR search engine: start request, comparator
// verdict going in, and the trial word and search status coming out.
interface sar_search_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic         cmp_gt;
    logic         cmp_lt;
    logic         cmp_eq;
    logic [N-1:0] trial;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         err;

    modport master (
        input  start, cmp_gt, cmp_lt, cmp_eq,
        output trial, busy, done, result, err
    );

    modport slave (
        output start, cmp_gt, cmp_lt, cmp_eq,
        input  trial, busy, done, result, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search: drives trial words to a magnitude comparator
// MSB-first and returns the unknown operand A, with optional settle wait per trial.
module sar_search_ctrl #(
    parameter int N      = 8,
    parameter int SETTLE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    sar_search_ctrl_if.master bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        TEST,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  trial_q, trial_d;
    logic [N-1:0]  result_q, result_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [N-1:0]  adjusted;
    logic          cmp_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= IW'(N - 1);
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        // The bit under test is kept when A is above the trial, cleared when below.
        adjusted           = trial_q;
        adjusted[idx_q]    = bus.cmp_gt;
        cmp_onehot = ( bus.cmp_gt & ~bus.cmp_lt & ~bus.cmp_eq) |
                     (~bus.cmp_gt &  bus.cmp_lt & ~bus.cmp_eq) |
                     (~bus.cmp_gt & ~bus.cmp_lt &  bus.cmp_eq);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    trial_d = {1'b1, {(N-1){1'b0}}};
                    idx_d   = IW'(N - 1);
                    cnt_d   = CW'(SETTLE);
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = TEST;
                end
            end
            TEST: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!cmp_onehot) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = DONE;
                end else if (bus.cmp_eq) begin
                    result_d = trial_q;
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    result_d = adjusted;
                    state_d  = DONE;
                end else begin
                    trial_d                  = adjusted;
                    trial_d[idx_q - IW'(1)]  = 1'b1;
                    idx_d                    = idx_q - IW'(1);
                    cnt_d                    = CW'(SETTLE);
                end
                if (state_d == DONE) begin
                    trial_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.trial  = trial_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: three instances (SETTLE 0/1/2) driven by a behavioural
// comparator; expected results queued at start and checked when done pulses.
module tb_sar_search_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sar_search_ctrl_if #(.N(8)) if0 ();
    sar_search_ctrl_if #(.N(8)) if1 ();
    sar_search_ctrl_if #(.N(8)) if2 ();

    sar_search_ctrl #(.N(8), .SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
    sar_search_ctrl #(.N(8), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
    sar_search_ctrl #(.N(8), .SETTLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));

    logic       start_v [3];
    logic [2:0] cmp_v   [3];
    logic [7:0] trial_w [3];
    logic [7:0] result_w[3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       err_w   [3];
    logic [7:0] last_res[3];

    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];
    assign {if0.cmp_gt, if0.cmp_lt, if0.cmp_eq} = cmp_v[0];
    assign {if1.cmp_gt, if1.cmp_lt, if1.cmp_eq} = cmp_v[1];
    assign {if2.cmp_gt, if2.cmp_lt, if2.cmp_eq} = cmp_v[2];
    assign trial_w[0]  = if0.trial;   assign trial_w[1]  = if1.trial;   assign trial_w[2]  = if2.trial;
    assign result_w[0] = if0.result;  assign result_w[1] = if1.result;  assign result_w[2] = if2.result;
    assign busy_w[0]   = if0.busy;    assign busy_w[1]   = if1.busy;    assign busy_w[2]   = if2.busy;
    assign done_w[0]   = if0.done;    assign done_w[1]   = if1.done;    assign done_w[2]   = if2.done;
    assign err_w[0]    = if0.err;     assign err_w[1]    = if1.err;     assign err_w[2]    = if2.err;

    typedef struct {
        int         sel;
        logic [7:0] res;
        logic       err;
    } exp_t;

    typedef struct {
        int         sel;
        logic [7:0] a;
        int         settle;
        bit         rnd_wait;
        int         err_eval;
        logic [2:0] err_vec;
    } vec_t;

    exp_t exp_q[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        assert_count++;
        if (act !== req) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [2:0] compare(input logic [7:0] a, input logic [7:0] t);
        return {a > t, a < t, a == t};
    endfunction

    // Number of evaluations: the search stops when the trial lands on A's lowest set bit.
    function automatic int expEvals(input logic [7:0] a);
        int tz;
        if (a == 8'h00) return 8;
        tz = 0;
        while (a[tz] == 1'b0) tz++;
        return 8 - tz;
    endfunction

    function automatic logic [7:0] expTrial(input logic [7:0] a, input int ev);
        int msk;
        if (ev < 1 || ev > 8) return 8'h00;
        msk = ~((1 << (9 - ev)) - 1);
        return 8'((int'(a) & msk) | (1 << (8 - ev)));
    endfunction

    task automatic pushExp(input int sel, input logic [7:0] a, input int err_eval);
        exp_t e;
        e.sel = sel;
        e.res = (err_eval > 0) ? 8'h00 : a;
        e.err = (err_eval > 0);
        exp_q.push_back(e);
    endtask

    // Runs one search whose accepting edge (E0) has just occurred.
    task automatic runBody(input int sel, input logic [7:0] a, input int settle, input bit rnd_wait,
                           input int err_eval, input logic [2:0] err_vec, input bit keep_start,
                           input int abort_at);
        int evals, exp_lat, ev;
        bit seen, aborted;
        evals   = (err_eval > 0) ? err_eval : expEvals(a);
        exp_lat = evals * (settle + 1);
        seen    = 1'b0;
        aborted = 1'b0;
        for (int j = 0; j < 64 && !seen && !aborted; j++) begin
            @(negedge clk);
            start_v[sel] = keep_start;
            if (j == abort_at) begin
                rst_n = 1'b0;
                #1;
                checkOutput("rstTrial", trial_w[sel], 0);
                checkOutput("rstBusy", busy_w[sel], 0);
                checkOutput("rstResult", result_w[sel], 0);
                checkOutput("rstErr", err_w[sel], 0);
                void'(exp_q.pop_back());
                for (int s = 0; s < 3; s++) last_res[s] = 8'h00;
                @(negedge clk);
                checkOutput("rstNoDone", done_w[sel], 0);
                rst_n   = 1'b1;
                aborted = 1'b1;
            end else if (done_w[sel]) begin
                seen = 1'b1;
                checkOutput("latency", j, exp_lat);
            end else begin
                checkOutput("busy", busy_w[sel], 1);
                if (j == 0) begin
                    checkOutput("errCleared", err_w[sel], 0);
                    checkOutput("resultHeld", result_w[sel], last_res[sel]);
                end
                ev = (j + 1) / (settle + 1);
                if ((j + 1) % (settle + 1) == 0) begin
                    checkOutput("trial", trial_w[sel], expTrial(a, ev));
                    cmp_v[sel] = (ev == err_eval) ? err_vec : compare(a, trial_w[sel]);
                end else begin
                    cmp_v[sel] = rnd_wait ? 3'($urandom) : compare(a, trial_w[sel]);
                end
            end
        end
        if (!aborted) begin
            checkOutput("doneSeen", seen, 1);
            @(negedge clk);
            checkOutput("donePulse", done_w[sel], 0);
            checkOutput("busyIdle", busy_w[sel], 0);
            checkOutput("trialZero", trial_w[sel], 0);
            checkOutput("resultKept", result_w[sel], last_res[sel]);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [7:0] a, input int settle, input bit rnd_wait,
                                 input int err_eval, input logic [2:0] err_vec, input bit keep_start,
                                 input int abort_at);
        pushExp(sel, a, err_eval);
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(posedge clk);
        runBody(sel, a, settle, rnd_wait, err_eval, err_vec, keep_start, abort_at);
    endtask

    // Scoreboard: each done pulse consumes the oldest expectation.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (done_w[s]) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpectedDone", done_w[s], 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("doneInstance", s, e.sel);
                    checkOutput("result", result_w[s], e.res);
                    checkOutput("err", err_w[s], e.err);
                    last_res[s] = e.res;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = '{0, 8'hB5, 0, 1'b0, 0, 3'b000};
        vecs[1] = '{0, 8'h80, 0, 1'b0, 0, 3'b000};
        vecs[2] = '{0, 8'h00, 0, 1'b0, 0, 3'b000};
        vecs[3] = '{0, 8'hFF, 0, 1'b0, 0, 3'b000};
        vecs[4] = '{2, 8'h3C, 2, 1'b1, 0, 3'b000};
        vecs[5] = '{0, 8'hB5, 0, 1'b0, 3, 3'b110};
        vecs[6] = '{0, 8'h5A, 0, 1'b0, 0, 3'b000};
        vecs[7] = '{0, 8'hB5, 0, 1'b0, 1, 3'b000};
        vecs[8] = '{1, 8'h01, 1, 1'b1, 0, 3'b000};

        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            start_v[s]  = 1'b0;
            cmp_v[s]    = 3'b000;
            last_res[s] = 8'h00;
        end
        repeat (2) @(negedge clk);
        checkOutput("resetTrial", trial_w[0], 0);
        checkOutput("resetBusy", busy_w[0], 0);
        checkOutput("resetDone", done_w[0], 0);
        checkOutput("resetResult", result_w[0], 0);
        checkOutput("resetErr", err_w[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].settle, vecs[i].rnd_wait,
                          vecs[i].err_eval, vecs[i].err_vec, 1'b0, -1);
        end

        $display("[TB] start held high across a search");
        applyStimulus(0, 8'h5A, 0, 1'b0, 0, 3'b000, 1'b1, -1);
        pushExp(0, 8'hC3, 0);
        @(posedge clk);
        runBody(0, 8'hC3, 0, 1'b0, 0, 3'b000, 1'b0, -1);

        $display("[TB] reset during a search");
        applyStimulus(0, 8'hB5, 0, 1'b0, 0, 3'b000, 1'b0, 4);
        applyStimulus(0, 8'hB5, 0, 1'b0, 0, 3'b000, 1'b0, -1);

        $display("[TB] exhaustive sweep, SETTLE 0 and 1");
        for (int a = 0; a < 256; a++) applyStimulus(0, 8'(a), 0, 1'b0, 0, 3'b000, 1'b0, -1);
        for (int a = 0; a < 256; a++) applyStimulus(1, 8'(a), 1, 1'b1, 0, 3'b000, 1'b0, -1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search engine: the initiator side of a magnitude comparator.
- Drives a trial word onto the comparator's B input and reads back the GT/LT/EQ result of A versus the trial.
- Binary-searches MSB-first and returns the value of the unknown operand A.
- Used for threshold discovery, SAR-style conversion and self-test of the comparator block.

Parameters:
- N, 8, width of trial and result words (N >= 2).
- SETTLE, 0, extra wait cycles after each new trial before the comparator result is sampled (0 = combinational comparator).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a search; sampled only in IDLE.
- cmp_gt  input  1  comparator result: A > trial.
- cmp_lt  input  1  comparator result: A < trial.
- cmp_eq  input  1  comparator result: A == trial.
- trial  output  N  registered word driven to comparator B input.
- busy  output  1  high from the edge after start until the final evaluation edge.
- done  output  1  one-cycle pulse, search complete.
- result  output  N  found value of A, held until the next accepted start.
- err  output  1  inconsistent comparator vector seen, held until the next accepted start.

Behaviour:
- Reset (async assert, sync release): state=IDLE; trial, result = 0; busy, done, err = 0; bit index = N-1; settle counter = 0.
- States: IDLE, TEST, DONE.
- IDLE:
  - start=1 at edge E0 -> trial <= 1<<(N-1), index <= N-1, cnt <= SETTLE, busy <= 1, err <= 0, go TEST.
  - start=0 -> hold.
- TEST, each edge:
  - If cnt != 0: cnt decrements, cmp inputs ignored.
  - Else evaluate, sampling the cmp inputs only at this edge:
    - Vector not one-hot (none or >1 high): err <= 1, result <= 0, go DONE.
    - cmp_eq: result <= trial, go DONE (early exit).
    - cmp_gt: keep bit[index].
    - cmp_lt: clear bit[index].
    - After keep/clear with index==0: result <= adjusted trial, go DONE.
    - After keep/clear with index>0: set bit[index-1], index decrements, cnt <= SETTLE.
- Transition into DONE: trial <= 0, busy <= 0, done <= 1 registered.
  - done is high for exactly the one cycle following the final evaluation edge.
  - DONE -> IDLE on the next edge; done <= 0.
- Latency: done rises k*(SETTLE+1) edges after E0, where k = number of evaluations (1..N).
  - Worst case is N*(SETTLE+1).
  - A start asserted in the DONE cycle is ignored; the earliest restart is in the following cycle.
- Start while busy or in DONE: ignored, no effect on the search.
- Consistent comparator: result == A for every A in 0..2^N-1.
  - A=0 takes N evaluations, all cmp_lt, result 0.
  - A=2^(N-1) exits on the first evaluation.
- Reset mid-search: immediate return to reset values; no done pulse; the partial result is discarded.
- result and err change only at the DONE transition or on reset; stable while busy=1.
- trial is registered (no combinational path from cmp_* to trial).

Test Plan:
- N=8, SETTLE=0, bench comparator with A=0xB5, start pulse at E0:
  - trial sequence 0x80,0xC0,0xA0,0xB0,0xB8,0xB4,0xB6,0xB5; cmp gt,lt,gt,gt,lt,gt,lt,eq.
  - done after E8 for one cycle; result=0xB5; err=0; trial returns to 0.
- N=8, A=0x80: single evaluation eq -> done after E1, result=0x80. A=0x00: eight lt evaluations -> result=0x00, err=0. A=0xFF: eight evaluations, last eq -> result=0xFF.
- SETTLE=2, A=0x3C:
  - each trial held 3 cycles; cmp_* toggled randomly during the two wait cycles has no effect.
  - done after E18 (A=0x3C needs 6 evaluations, the 6th eq at trial 0x3C), result=0x3C.
- Error injection:
  - force cmp_gt=cmp_lt=1 at the third evaluation -> err=1, result=0, done pulses.
  - next start clears err; all-zero cmp vector also -> err=1.
- Control edges:
  - start held high through an entire search -> exactly one search per IDLE entry; start during DONE is ignored.
  - rst_n low at E4 mid-search -> all outputs 0 asynchronously, no done; new search after release returns the correct result.
- Exhaustive: SETTLE=0 and SETTLE=1, N=8, all 256 values of A -> result==A, err=0, evaluation count ≤ 8, done width exactly one cycle.
